// File: rtl/stage_pkg.sv
// Shared constants and types for the multicycle stage sequencer.
package stage_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BLT = 7'b1100011;

  localparam logic [3:0] EN_NONE   = 4'b0000;
  localparam logic [3:0] EN_FETCH  = 4'b0001;
  localparam logic [3:0] EN_DECODE = 4'b0010;
  localparam logic [3:0] EN_EXEC   = 4'b0100;
  localparam logic [3:0] EN_MEM    = 4'b1000;

  // Binary encoding; 3'b111 is the single unreachable code.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_IMEM_TO = 2'b10;
  localparam logic [1:0] FC_DMEM_TO = 2'b11;

  function automatic logic [3:0] en_of(input state_t s);
    case (s)
      ST_FETCH:  return EN_FETCH;
      ST_DECODE: return EN_DECODE;
      ST_EXEC:   return EN_EXEC;
      ST_MEM:    return EN_MEM;
      default:   return EN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wait_watchdog.sv
// Counts consecutive not-ready cycles of a memory handshake and flags a timeout.
module wait_watchdog #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en && !ready) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The WAIT_MAX-th waiting cycle trips the timeout unless ready shows up in it.
  assign timeout = cnt_en && !ready && (cnt == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC -> [MEM] -> WB with
// memory handshakes, a shared wait watchdog and a retired-instruction counter.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [3:0]       en,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     nxt;
  logic [6:0] op_q;
  logic [6:0] op_nxt;
  logic       taken_q;
  logic       taken_nxt;
  logic [1:0] code_nxt;

  logic wd_active;
  logic wd_ready;
  logic wd_timeout;

  assign wd_active = (state == ST_FETCH) || (state == ST_MEM);
  assign wd_ready  = (state == ST_MEM) ? dmem_ready : imem_ready;

  // Cleared in every non-waiting state, so entry to FETCH or MEM always starts at zero.
  wait_watchdog #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!wd_active),
    .cnt_en (wd_active),
    .ready  (wd_ready),
    .timeout(wd_timeout)
  );

  always_comb begin
    nxt       = state;
    op_nxt    = op_q;
    taken_nxt = taken_q;
    code_nxt  = fault_code;
    case (state)
      ST_IDLE: begin
        if (run) nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          nxt = ST_DECODE;
        end else if (wd_timeout) begin
          nxt      = ST_HALT;
          code_nxt = FC_IMEM_TO;
        end
      end
      ST_DECODE: begin
        nxt = ST_EXEC;
      end
      ST_EXEC: begin
        op_nxt    = opcode;
        taken_nxt = branch_taken;
        case (opcode)
          OP_R, OP_BLT: nxt = ST_WB;
          OP_LW, OP_SW: nxt = ST_MEM;
          default: begin
            nxt      = ST_HALT;
            code_nxt = FC_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          nxt = ST_WB;
        end else if (wd_timeout) begin
          nxt      = ST_HALT;
          code_nxt = FC_DMEM_TO;
        end
      end
      ST_WB: begin
        nxt = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        if (clear) begin
          nxt      = ST_IDLE;
          code_nxt = FC_NONE;
        end
      end
      default: begin
        nxt      = ST_HALT;
        code_nxt = FC_ILLEGAL;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= '0;
      taken_q       <= 1'b0;
      en            <= EN_NONE;
      imem_req      <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      reg_we        <= 1'b0;
      pc_we         <= 1'b0;
      pc_sel_branch <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= FC_NONE;
      retired       <= '0;
    end else begin
      state         <= nxt;
      op_q          <= op_nxt;
      taken_q       <= taken_nxt;
      fault_code    <= code_nxt;
      en            <= en_of(nxt);
      imem_req      <= (nxt == ST_FETCH);
      dmem_req      <= (nxt == ST_MEM);
      dmem_we       <= (nxt == ST_MEM) && (op_nxt == OP_SW);
      reg_we        <= (nxt == ST_WB) && ((op_nxt == OP_R) || (op_nxt == OP_LW));
      pc_we         <= (nxt == ST_WB);
      pc_sel_branch <= (nxt == ST_WB) && (op_nxt == OP_BLT) && taken_nxt;
      busy          <= (nxt != ST_IDLE) && (nxt != ST_HALT);
      fault         <= (nxt == ST_HALT);
      if (state == ST_WB) retired <= retired + CNT_W'(1);
    end
  end

endmodule
